ram_req_sequencer: RTL
======================

// Module: ram_req_sequencer
// PURPOSE
//   Request front-end directly upstream of the single-port RAM.
//   - Accepts read/write requests on a valid/ready interface and buffers them in a small FIFO.
//   - Issues them to the RAM strictly in order, at most one RAM op per cycle.
//   - Returns read data on a valid/ready response channel.
//   - Decouples testbench/master traffic from RAM timing and enforces read ordering.
// PARAMETERS
//   ADDR_WIDTH   4   RAM address width (default from ConfigParams_pkg)
//   DATA_WIDTH   32  RAM data width (default from ConfigParams_pkg)
//   FIFO_DEPTH   4   request FIFO entries, power of two, >=2
//   RD_LATENCY   1   cycles from ram_en (read) high to ram_dout valid, >=1
// PORTS
//   clk        in   1           single clock, rising edge
//   rst_n      in   1           asynchronous, active-low reset
//   req_valid  in   1           request present
//   req_ready  out  1           FIFO can accept (= !full)
//   req_write  in   1           1=write, 0=read
//   req_addr   in   ADDR_WIDTH  request address
//   req_wdata  in   DATA_WIDTH  write data (ignored for reads)
//   rsp_valid  out  1           read response held valid
//   rsp_ready  in   1           consumer accepts response
//   rsp_rdata  out  DATA_WIDTH  read data
//   rsp_addr   out  ADDR_WIDTH  address of the read being returned
//   ram_en     out  1           RAM op strobe, registered
//   ram_we     out  1           RAM write enable, registered
//   ram_addr   out  ADDR_WIDTH  RAM address, registered
//   ram_din    out  DATA_WIDTH  RAM write data, registered
//   ram_dout   in   DATA_WIDTH  RAM read data
//   busy       out  1           FIFO non-empty OR state!=IDLE OR ram_en
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - All outputs 0; req_ready=1 after release.
//     - FIFO pointers/count cleared; FSM=IDLE; RD counter=0.
//     - Mid-operation reset drops queued and in-flight ops; no late rsp_valid after release.
//   Push
//     - Occurs on req_valid & req_ready at the clock edge.
//     - req_ready = !full; no push while full, even if a pop occurs in the same cycle.
//   FIFO
//     - Pointers are log2(FIFO_DEPTH) bits, wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
//     - Simultaneous push+pop (not full, not empty) leaves count unchanged.
//   FSM states
//     - IDLE: if FIFO non-empty, pop head and register ram_en=1, ram_we=head.write, ram_addr, ram_din.
//       - Write: stay IDLE, so back-to-back writes issue one per cycle.
//       - Read: go to WAIT_RD, counter=RD_LATENCY.
//     - WAIT_RD: no issue. ram_en high in cycle C => ram_dout is captured at the end of cycle C+RD_LATENCY
//       into rsp_rdata, with rsp_addr=issued addr, rsp_valid=1 from cycle C+RD_LATENCY+1. Go to RSP.
//     - RSP: rsp_valid/rsp_rdata/rsp_addr held stable until rsp_ready. On handshake: rsp_valid=0, go to IDLE.
//       Next issue occurs at the earliest in the following cycle.
//   ram_en, ram_we
//     - ram_en high exactly one cycle per popped op.
//     - ram_we=0 whenever ram_en=0; ram_addr/ram_din hold last values.
//   Ordering and latency
//     - Strict program order: a read blocks all later ops (including writes) until its response is accepted.
//       Read-after-write to the same address therefore returns the new data.
//     - Latency, empty FIFO, rsp_ready=1: write accepted at edge E -> ram_en high in cycle after E+1 edge.
//       Read: rsp_valid 2+RD_LATENCY cycles after acceptance.
//   Arithmetic
//     - No data arithmetic; addresses pass unmodified (wrap is the RAM's concern).
// STRUCTURE
//   Shared package (ConfigParams_pkg)
//     - ADDR_WIDTH and DATA_WIDTH defaults.
//     - typedef struct packed {logic write; logic [ADDR_WIDTH-1:0] addr; logic [DATA_WIDTH-1:0] data;} ram_req_t.
//     - typedef enum logic [1:0] {IDLE, WAIT_RD, RSP} seq_state_e.
//   Sub-module ram_req_fifo: synchronous FIFO of ram_req_t with full/empty/count and async active-low reset.
//   Top holds the FSM, RD counter, RAM output registers and the response register.
// TESTING
//   1. Reset mid-read (rst_n=0 during WAIT_RD) -> all outputs 0 immediately; no rsp_valid after release; req_ready=1.
//   2. Write 0xDEADBEEF @4, then read @4, rsp_ready=1 -> ram_en/ram_we=1,addr=4 then ram_en=1,we=0,addr=4;
//      rsp_rdata=0xDEADBEEF, rsp_addr=4, rsp_valid one cycle.
//   3. Push 5 writes with no pops possible (hold a read at head with rsp_ready=0) -> req_ready=0 after 4 entries;
//      5th accepted only after a pop.
//   4. Writes to addr 0..15 on consecutive cycles -> ram_en high 16 consecutive cycles; pointers wrap; no drops.
//   5. Read @3 with rsp_ready=0 for 10 cycles -> rsp_valid/rsp_rdata stable; no ram_en until the handshake.
//   6. RD_LATENCY=3 build, read @7 -> ram_dout captured exactly 3 cycles after ram_en; rsp_valid on cycle +4.

Source files
------------

// File: rtl/ram_req_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ram_req_sequencer_pkg
//   Shared configuration for the RAM request front-end.
//   - DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default RAM geometry
//   - ram_req_t                       : one queued request at default geometry
//   - seq_state_e                     : issue/response sequencer states
// ---------------------------------------------------------------------------
package ram_req_sequencer_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 32;

    typedef struct packed {
        logic                      write;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } ram_req_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RD = 2'd1,
        RSP     = 2'd2
    } seq_state_e;

endpackage

// File: rtl/ram_req_fifo.sv
// ---------------------------------------------------------------------------
// ram_req_fifo
//   Synchronous FIFO holding packed requests for the RAM sequencer.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset (pointers/count only)
//     push, wdata : write strobe and entry; ignored while full
//     pop         : read strobe; ignored while empty
//     rdata       : current head entry (combinational from storage)
//     full, empty : occupancy flags
//     count       : number of stored entries, log2(DEPTH)+1 bits
// ---------------------------------------------------------------------------
module ram_req_fifo
    import ram_req_sequencer_pkg::*;
#(
    parameter int WIDTH = $bits(ram_req_t),
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr];

    // A full FIFO never accepts, even when the head leaves in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are exactly AW bits wide so they wrap at DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries data only; pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/ram_req_sequencer.sv
// ---------------------------------------------------------------------------
// ram_req_sequencer
//   In-order request front-end for a single-port RAM. Requests are queued in
//   a small FIFO and issued one per cycle; a read blocks every later request
//   until its response has been accepted on the response channel.
//   Ports:
//     clk, rst_n                 : clock, asynchronous active-low reset
//     req_valid/req_ready        : request handshake (ready = FIFO not full)
//     req_write/addr/wdata       : request contents
//     rsp_valid/rsp_ready        : read response handshake
//     rsp_rdata/rsp_addr         : returned data and the address it came from
//     ram_en/we/addr/din         : registered RAM command
//     ram_dout                   : RAM read data, valid RD_LATENCY cycles after ram_en
//     busy                       : queue non-empty, op in flight, or command on the bus
// ---------------------------------------------------------------------------
module ram_req_sequencer
    import ram_req_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  busy
);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    localparam int REQ_W   = $bits(req_t);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(RD_LATENCY + 1);

    req_t             push_req;
    req_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FIFO_AW:0] fifo_count;
    logic             push;
    logic             pop;

    seq_state_e       state;
    seq_state_e       state_nxt;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] rd_cnt_nxt;
    logic             issue;
    logic             capture;
    logic             rsp_done;

    // Ready is forced low while reset is asserted so every output reads 0.
    assign req_ready = rst_n && !fifo_full;
    assign push      = req_valid && req_ready;
    assign push_req  = '{write: req_write, addr: req_addr, data: req_wdata};

    ram_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_req),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sequencer: writes issue back-to-back from IDLE; a read parks the
    // sequencer until its data has been returned and accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rd_cnt <= '0;
        end else begin
            state  <= state_nxt;
            rd_cnt <= rd_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        rd_cnt_nxt = rd_cnt;
        pop        = 1'b0;
        issue      = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop   = 1'b1;
                    issue = 1'b1;
                    if (!head.write) begin
                        state_nxt  = WAIT_RD;
                        rd_cnt_nxt = CNT_W'(RD_LATENCY);
                    end
                end
            end
            WAIT_RD: begin
                // The counter holds RD_LATENCY during the ram_en cycle and
                // reaches zero in the cycle whose closing edge sees valid data.
                if (rd_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RSP;
                end else begin
                    rd_cnt_nxt = rd_cnt - CNT_W'(1);
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // RAM command registers: strobes are one-cycle pulses, address and data
    // keep their last values between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            ram_en <= issue;
            ram_we <= issue && head.write;
            if (issue) begin
                ram_addr <= head.addr;
                ram_din  <= head.data;
            end
        end
    end

    // Response register. ram_addr still holds the read's address while the
    // sequencer waits, because nothing else can issue in the meantime.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_addr  <= '0;
        end else begin
            if (capture) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= ram_dout;
                rsp_addr  <= ram_addr;
            end else if (rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign busy = (fifo_count != '0) || (state != IDLE) || ram_en;

endmodule
